// File: rtl/bird_if.sv
// bird_if: game-state/tick/flap inputs and bird position outputs of the bird physics unit
interface bird_if;
    logic [1:0] state_i;
    logic       frame_tick_i;
    logic       flap_i;
    logic [9:0] bird_y_o;
    logic [4:0] bird_vel_o;
    logic       failed_o;
    modport master (output state_i, frame_tick_i, flap_i, input bird_y_o, bird_vel_o, failed_o);
    modport slave (input state_i, frame_tick_i, flap_i, output bird_y_o, bird_vel_o, failed_o);
endinterface

// File: rtl/bird_physics.sv
// bird_physics: per-frame gravity, flap and ground/ceiling handling for the bird
module bird_physics #(
    parameter int Y_INIT   = 240,
    parameter int Y_GROUND = 464,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int V_MAX    = 8
) (
    input  logic   clk,
    input  logic   rst,
    bird_if.slave  bus
);
    localparam logic [1:0]         ST_RUN = 2'd1;
    localparam logic [1:0]         ST_FAIL = 2'd2;
    localparam logic signed [11:0] GR = 12'(GRAVITY);
    localparam logic signed [11:0] FV = 12'(FLAP_VEL);
    localparam logic signed [11:0] VM = 12'(V_MAX);
    localparam logic signed [11:0] YG = 12'(Y_GROUND);

    logic [9:0]         y_q, y_d;
    logic [4:0]         vel_q, vel_d;
    logic               fail_q, fail_d;
    logic               pend_q, pend_d;
    logic               flap_prev_q;
    logic               rise;
    logic signed [11:0] vel_ext, grav, vel_new, sum;

    assign rise    = bus.flap_i & ~flap_prev_q;
    assign vel_ext = {{7{vel_q[4]}}, vel_q};
    assign grav    = vel_ext + GR;
    assign vel_new = (pend_q | rise) ? FV : (grav > VM ? VM : grav);
    assign sum     = $signed({2'b00, y_q}) + vel_new;

    // next-state: INIT/3 forces the start position, FAILED freezes, RUNNING steps on frame ticks
    always_comb begin
        y_d    = y_q;
        vel_d  = vel_q;
        fail_d = fail_q;
        pend_d = pend_q;
        if (bus.state_i == ST_RUN) begin
            if (bus.frame_tick_i) begin
                pend_d = 1'b0;
                if (!fail_q) begin
                    if (sum < 0) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else if (sum >= YG) begin
                        y_d    = 10'(Y_GROUND);
                        vel_d  = '0;
                        fail_d = 1'b1;
                    end else begin
                        y_d   = sum[9:0];
                        vel_d = vel_new[4:0];
                    end
                end
            end else begin
                pend_d = pend_q | rise;
            end
        end else if (bus.state_i == ST_FAIL) begin
            pend_d = 1'b0;
        end else begin
            y_d    = 10'(Y_INIT);
            vel_d  = '0;
            fail_d = 1'b0;
            pend_d = 1'b0;
        end
    end

    // state registers and flap edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= 10'(Y_INIT);
            vel_q       <= '0;
            fail_q      <= 1'b0;
            pend_q      <= 1'b0;
            flap_prev_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            vel_q       <= vel_d;
            fail_q      <= fail_d;
            pend_q      <= pend_d;
            flap_prev_q <= bus.flap_i;
        end
    end

    assign bus.bird_y_o   = y_q;
    assign bus.bird_vel_o = vel_q;
    assign bus.failed_o   = fail_q;
endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: table vectors, hand sequences and randomized run against a behavioural model
module tb_bird_physics;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bird_if bus ();
    bird_physics dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [1:0] s;
        logic       t;
        logic       f;
        int         y;
        int         v;
        int         fl;
    } vec_t;

    vec_t tbl[17];
    int n_cmp = 0;
    int n_err = 0;
    int my, mv, mf, mp, mprev;

    task automatic model(input logic r, input logic [1:0] s, input logic t, input logic f);
        int e, v, p;
        if (r) begin
            my = 240; mv = 0; mf = 0; mp = 0; mprev = 0;
            return;
        end
        e = (f && !mprev) ? 1 : 0;
        mprev = f ? 1 : 0;
        if (s == 2'd1) begin
            if (t) begin
                if (!mf) begin
                    v = (mp || e) ? -8 : ((mv + 1 > 8) ? 8 : mv + 1);
                    p = my + v;
                    if (p < 0) begin my = 0; mv = 0; end
                    else if (p >= 464) begin my = 464; mv = 0; mf = 1; end
                    else begin my = p; mv = v; end
                end
                mp = 0;
            end else if (e) mp = 1;
        end else if (s == 2'd2) mp = 0;
        else begin
            my = 240; mv = 0; mf = 0; mp = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] s, input logic t, input logic f);
        @(negedge clk);
        rst = r;
        bus.state_i = s;
        bus.frame_tick_i = t;
        bus.flap_i = f;
        model(r, s, t, f);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input int y, input int v, input int f);
        chk({nm, ".y"}, int'(bus.bird_y_o), y);
        chk({nm, ".vel"}, int'($signed(bus.bird_vel_o)), v);
        chk({nm, ".failed"}, int'(bus.failed_o), f);
    endtask

    initial begin
        logic       r, t, f;
        logic [1:0] s;
        bus.state_i = 2'd0;
        bus.frame_tick_i = 1'b0;
        bus.flap_i = 1'b0;
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 240, 0, 0};
        tbl[1]  = '{1'b0, 2'd1, 1'b1, 1'b0, 241, 1, 0};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 1'b0, 243, 2, 0};
        tbl[3]  = '{1'b0, 2'd1, 1'b1, 1'b0, 246, 3, 0};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 1'b1, 246, 3, 0};
        tbl[5]  = '{1'b0, 2'd1, 1'b0, 1'b0, 246, 3, 0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 1'b1, 246, 3, 0};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 1'b0, 238, -8, 0};
        tbl[8]  = '{1'b0, 2'd2, 1'b1, 1'b1, 238, -8, 0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 1'b0, 231, -7, 0};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 1'b1, 223, -8, 0};
        tbl[11] = '{1'b0, 2'd1, 1'b1, 1'b0, 216, -7, 0};
        tbl[12] = '{1'b0, 2'd3, 1'b1, 1'b1, 240, 0, 0};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 240, 0, 0};
        tbl[14] = '{1'b0, 2'd1, 1'b0, 1'b1, 240, 0, 0};
        tbl[15] = '{1'b1, 2'd1, 1'b0, 1'b0, 240, 0, 0};
        tbl[16] = '{1'b0, 2'd1, 1'b1, 1'b0, 241, 1, 0};
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].f);
            chk3($sformatf("vec%0d", i), tbl[i].y, tbl[i].v, tbl[i].fl);
        end

        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b0, 2'd1, 1'b1, 1'b0);
            chk($sformatf("sat%0d.vel", i), int'($signed(bus.bird_vel_o)), i > 8 ? 8 : i);
        end

        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 2'd1, 1'b1, 1'b0);
        chk3("fall7", 268, 7, 0);
        for (int i = 0; i < 33; i++) begin
            cyc(1'b0, 2'd1, 1'b1, 1'b1);
            cyc(1'b0, 2'd1, 1'b0, 1'b0);
        end
        chk3("near_top", 4, -8, 0);
        cyc(1'b0, 2'd1, 1'b1, 1'b1);
        chk3("ceiling", 0, 0, 0);

        cyc(1'b0, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++) cyc(1'b0, 2'd1, 1'b1, 1'b0);
        chk3("near_ground", 460, 8, 0);
        cyc(1'b0, 2'd1, 1'b1, 1'b0);
        chk3("ground", 464, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'd1, 1'b1, i[0]);
        chk3("crashed_run", 464, 0, 1);
        cyc(1'b0, 2'd2, 1'b1, 1'b1);
        cyc(1'b0, 2'd2, 1'b1, 1'b0);
        chk3("crashed_frozen", 464, 0, 1);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk3("reinit", 240, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
                0: s = 2'd0;
                1: s = 2'd2;
                2: s = 2'd3;
                default: s = 2'd1;
            endcase
            t = ($urandom_range(0, 2) == 0);
            f = r ? 1'b0 : 1'($urandom_range(0, 1));
            cyc(r, s, t, f);
            chk3($sformatf("rnd%0d", i), my, mv, mf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
